mac_burst_ctrl: RTL and testbench

//  Parametrised burst sequencer for the FP16 MAC datapath; generalises the fixed 8-beat wrapper.

---
 rtl/mac_burst_ctrl.sv | 115 +++++++++++
 tb/tb_mac_burst_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_burst_ctrl.sv
// Burst sequencer for the FP16 MAC datapath: accepts a programmable-length
// operand burst, feeds the external MAC core, waits out its latency and
// captures the accumulated result.
module mac_burst_ctrl #(
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 8,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              clr_acc,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_en,
    output logic              mac_clr,
    input  logic [DATA_W-1:0] mac_result,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              done,
    output logic              busy,
    output logic [CNT_W-1:0]  count
);

    // Drain counter must hold MAC_LAT; +2 keeps the width >= 1 for MAC_LAT == 0.
    localparam int DRN_W = $clog2(MAC_LAT + 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  len_q;
    logic [DRN_W-1:0]  drain_cnt;
    logic              zero_len;
    logic              beat;
    logic              last_beat;

    // abort wins over a same-cycle beat, so the beat is simply not taken.
    assign beat      = (state == RUN) && in_valid && !abort;
    assign last_beat = beat && (count == len_q - 1'b1);

    assign in_ready     = (state == RUN);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign result_valid = (state == DONE) && !zero_len;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = (len == '0) ? DONE : RUN;
            RUN:   if (abort) next_state = IDLE;
                   else if (last_beat) next_state = DRAIN;
            DRAIN: if (abort) next_state = IDLE;
                   else if (drain_cnt == '0) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand staging, beat counting, drain timing, result capture.
    // The drain counter is loaded with MAC_LAT on the last-beat edge and the
    // capture happens on the edge after it has reached 0, i.e. MAC_LAT+1 edges
    // after the last beat: mac_result reflects that beat from MAC_LAT edges on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q     <= '0;
            count     <= '0;
            drain_cnt <= '0;
            zero_len  <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            result    <= '0;
        end else begin
            mac_a   <= '0;
            mac_b   <= '0;
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    len_q    <= len;
                    count    <= '0;
                    mac_clr  <= clr_acc;
                    zero_len <= (len == '0);
                end
                RUN: if (beat) begin
                    mac_a  <= a_in;
                    mac_b  <= b_in;
                    mac_en <= 1'b1;
                    count  <= count + 1'b1;
                    if (last_beat) drain_cnt <= DRN_W'(MAC_LAT);
                end
                DRAIN: if (!abort) begin
                    if (drain_cnt == '0) result <= mac_result;
                    else                 drain_cnt <= drain_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_burst_ctrl.sv
// Scoreboard bench for mac_burst_ctrl with a behavioural MAC core model.
module tb_mac_burst_ctrl;

    localparam int DATA_W  = 16;
    localparam int CNT_W   = 8;
    localparam int MAC_LAT = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  len = '0;
    logic              clr_acc = 1'b0;
    logic              abort = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] a_in = '0, b_in = '0;
    logic [DATA_W-1:0] mac_a, mac_b;
    logic              mac_en, mac_clr;
    logic [DATA_W-1:0] mac_result;
    logic [DATA_W-1:0] result;
    logic              result_valid, done, busy;
    logic [CNT_W-1:0]  count;

    mac_burst_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .clr_acc(clr_acc),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .mac_a(mac_a), .mac_b(mac_b),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_result(mac_result),
        .result(result), .result_valid(result_valid), .done(done),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // MAC core model restricted to the small FP16 values used here.
    function automatic int dec(input logic [15:0] v);
        case (v)
            16'h3C00: return 1;
            16'h4000: return 2;
            default:  return 0;
        endcase
    endfunction

    function automatic logic [15:0] enc(input int v);
        case (v)
            0: return 16'h0000;
            1: return 16'h3C00;
            2: return 16'h4000;
            3: return 16'h4200;
            4: return 16'h4400;
            6: return 16'h4600;
            8: return 16'h4800;
            default: return 16'hFFFF;
        endcase
    endfunction

    // Two edges from a registered beat to mac_result: accumulate, then output.
    int acc_int;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_int    <= 0;
            mac_result <= '0;
        end else begin
            acc_int    <= (mac_clr ? 0 : acc_int) + (mac_en ? dec(mac_a) * dec(mac_b) : 0);
            mac_result <= enc(acc_int);
        end
    end

    typedef struct {
        logic        rv;
        logic [15:0] res;
        logic [7:0]  cnt;
        int          at_edge;
        int          en;
        logic        clr;
    } sb_t;

    sb_t q[$];
    int  nvec = 0;
    int  nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        nvec++;
        nfail++;
        $display("FAIL %s", nm);
    endtask

    // Monitor: pops an expectation on every done pulse.
    int   en_cnt = 0;
    logic saw_clr = 1'b0;
    always @(negedge clk) begin
        sb_t x;
        if (reset) begin
            if (start && !busy) begin
                en_cnt  = 0;
                saw_clr = 1'b0;
            end
            if (mac_clr) saw_clr = 1'b1;
            if (mac_en) begin
                en_cnt++;
                chk("clr_with_en", 32'(mac_clr), 32'd0);
            end
            if (result_valid && !done) fail("result_valid_without_done");
            if (done) begin
                if (q.size() == 0) fail("unexpected_done");
                else begin
                    x = q.pop_front();
                    chk("result_valid", 32'(result_valid), 32'(x.rv));
                    chk("result", 32'(result), 32'(x.res));
                    chk("count_at_done", 32'(count), 32'(x.cnt));
                    chk("done_edge", 32'(cyc), 32'(x.at_edge));
                    chk("mac_en_beats", 32'(en_cnt), 32'(x.en));
                    chk("mac_clr_seen", 32'(saw_clr), 32'(x.clr));
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic start_burst(input int n, input logic clr);
        start = 1'b1; len = CNT_W'(n); clr_acc = clr;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] a, input logic [15:0] b, output int e);
        bit ok;
        ok = 0;
        in_valid = 1'b1; a_in = a; b_in = b;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) begin
            fail("beat_timeout");
            @(negedge clk);
        end
        @(posedge clk); #1;
        e = cyc;
        in_valid = 1'b0; a_in = '0; b_in = '0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50 && busy; k++) begin
            @(posedge clk); #1;
        end
        if (busy) fail("idle_timeout");
        @(posedge clk); #1;
    endtask

    task automatic burst(input int n, input logic clr, input logic [15:0] a, input logic [15:0] b,
                         input int gap, input logic [15:0] exp_res, input logic exp_rv);
        int  e;
        sb_t x;
        start_burst(n, clr);
        e = cyc;
        for (int i = 0; i < n; i++) begin
            beat(a, b, e);
            chk("count_beat", 32'(count), 32'(i + 1));
            if (i < n - 1) repeat (gap) begin @(posedge clk); #1; end
        end
        x.rv = exp_rv; x.res = exp_res; x.cnt = 8'(n);
        x.at_edge = (n == 0) ? e : e + MAC_LAT + 1;
        x.en = n; x.clr = clr;
        q.push_back(x);
        wait_idle();
    endtask

    initial begin
        int  e;
        sb_t x;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({in_ready, mac_en, mac_clr, result_valid, done, busy}), 32'd0);
        chk("rst_ops", {mac_a, mac_b}, 32'd0);
        chk("rst_res_cnt", 32'({result, count}), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // 4 x (1.0*2.0) with clear -> 8.0
        burst(4, 1'b1, 16'h3C00, 16'h4000, 0, 16'h4800, 1'b1);
        // 3 x (1.0*1.0) with 2-cycle stalls -> 3.0
        burst(3, 1'b1, 16'h3C00, 16'h3C00, 2, 16'h4200, 1'b1);
        // Two len=2 bursts, second keeps the accumulator -> 2.0 then 4.0
        burst(2, 1'b1, 16'h3C00, 16'h3C00, 0, 16'h4000, 1'b1);
        burst(2, 1'b0, 16'h3C00, 16'h3C00, 0, 16'h4400, 1'b1);
        // Zero-length: done only, result held
        burst(0, 1'b0, 16'h3C00, 16'h3C00, 0, 16'h4400, 1'b0);

        // Abort after 2 of 5 beats; a same-cycle beat must be refused
        start_burst(5, 1'b1);
        beat(16'h3C00, 16'h4000, e);
        beat(16'h3C00, 16'h4000, e);
        abort = 1'b1; in_valid = 1'b1; a_in = 16'h3C00; b_in = 16'h4000;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_count", 32'(count), 32'd2);
        chk("abort_mac_en", 32'(mac_en), 32'd0);
        chk("abort_result", 32'(result), 32'h4400);
        repeat (3) begin @(posedge clk); #1; end

        // Start while busy must not reload len
        start_burst(3, 1'b1);
        beat(16'h3C00, 16'h3C00, e);
        start = 1'b1; len = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_start_ignored", 32'(busy), 32'd1);
        beat(16'h3C00, 16'h3C00, e);
        beat(16'h3C00, 16'h3C00, e);
        x.rv = 1'b1; x.res = 16'h4200; x.cnt = 8'd3;
        x.at_edge = e + MAC_LAT + 1; x.en = 3; x.clr = 1'b1;
        q.push_back(x);
        wait_idle();

        // Reset in the middle of DRAIN
        start_burst(2, 1'b1);
        beat(16'h3C00, 16'h4000, e);
        beat(16'h3C00, 16'h4000, e);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("drain_rst_ctrl", 32'({in_ready, mac_en, mac_clr, result_valid, done, busy}), 32'd0);
        chk("drain_rst_ops", {mac_a, mac_b}, 32'd0);
        chk("drain_rst_res_cnt", 32'({result, count}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        burst(1, 1'b1, 16'h3C00, 16'h4000, 0, 16'h4000, 1'b1);

        repeat (5) begin @(posedge clk); #1; end
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
